// File: rtl/lsu_rv64_if.sv
// lsu_rv64_if
//   Bundles the signals between the execute stage, the load/store unit and the
//   byte-addressed data memory.
//   slave  : the load/store unit (accepts requests, drives the memory port).
//   master : the environment (issues requests, models the data memory).
//   Request : req_valid, req_ready, req_addr, req_wdata, req_store, req_funct3
//   Response: resp_valid, resp_data, resp_misaligned, resp_fault
//   Memory  : mem_addr, mem_write_data, mem_write_en, mem_funct3, mem_read_data
interface lsu_rv64_if #(
   parameter int AddrWidth = 14
);
   logic                 req_valid;
   logic                 req_ready;
   logic [63:0]          req_addr;
   logic [63:0]          req_wdata;
   logic                 req_store;
   logic [2:0]           req_funct3;
   logic                 resp_valid;
   logic [63:0]          resp_data;
   logic                 resp_misaligned;
   logic                 resp_fault;
   logic [AddrWidth-1:0] mem_addr;
   logic [63:0]          mem_write_data;
   logic                 mem_write_en;
   logic [2:0]           mem_funct3;
   logic [63:0]          mem_read_data;

   modport slave (
      input  req_valid, req_addr, req_wdata, req_store, req_funct3, mem_read_data,
      output req_ready, resp_valid, resp_data, resp_misaligned, resp_fault,
             mem_addr, mem_write_data, mem_write_en, mem_funct3
   );

   modport master (
      output req_valid, req_addr, req_wdata, req_store, req_funct3, mem_read_data,
      input  req_ready, resp_valid, resp_data, resp_misaligned, resp_fault,
             mem_addr, mem_write_data, mem_write_en, mem_funct3
   );
endinterface

// File: rtl/lsu_rv64.sv
// lsu_rv64
//   RV64 load/store unit in front of a byte-addressed data memory. One request
//   is accepted in IDLE, checked for encoding, range and alignment, then either
//   answered directly (fault / misaligned) or performed as a single memory
//   cycle. A one-cycle response pulse carries the load data or the flags.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset
//     bus      : lsu_rv64_if.slave (request, response and memory port)
//   Build option:
//     LSU_MISALIGNED_SPLIT_EN - when defined, legal in-range misaligned accesses
//     are split into byte accesses instead of being reported as misaligned.
module lsu_rv64 #(
   parameter int AddrWidth = 14
) (
   input logic       clk,
   input logic       rst,
   lsu_rv64_if.slave bus
);

`ifdef LSU_MISALIGNED_SPLIT_EN
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, SPLIT = 2'd2, RESP = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd3} state_t;
`endif

   state_t               state, state_nxt;
   logic                 store_q;
   logic [2:0]           funct3_q;
   logic [63:0]          resp_data_q;
   logic                 mis_q;
   logic                 fault_q;
   logic [AddrWidth-1:0] mem_addr_q;
   logic [63:0]          mem_wdata_q;

   // request decode, evaluated against the live request in IDLE
   logic [2:0]           size_m1;
   logic                 illegal;
   logic [AddrWidth:0]   last_byte;
   logic                 out_of_range;
   logic                 misaligned;
   logic                 reject;

   always_comb begin
      case (bus.req_funct3[1:0])
         2'd0:    size_m1 = 3'd0;
         2'd1:    size_m1 = 3'd1;
         2'd2:    size_m1 = 3'd3;
         default: size_m1 = 3'd7;
      endcase
   end

   assign illegal      = bus.req_store ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
   // one extra bit catches an access that runs past the top of memory
   assign last_byte    = {1'b0, bus.req_addr[AddrWidth-1:0]} + {{(AddrWidth-2){1'b0}}, size_m1};
   assign out_of_range = (bus.req_addr[63:AddrWidth] != '0) || last_byte[AddrWidth];
   assign misaligned   = (bus.req_addr[2:0] & size_m1) != 3'b000;
   assign reject       = illegal || out_of_range;

`ifdef LSU_MISALIGNED_SPLIT_EN
   logic [2:0]  k_q;
   logic [2:0]  last_k;
   logic [63:0] asm_data;

   // sign- or zero-extend the assembled bytes according to the load type
   function automatic logic [63:0] load_ext(input logic [63:0] raw, input logic [2:0] f3);
      logic signed [63:0] ext;
      case (f3)
         3'b000:  ext = 64'($signed(raw[7:0]));
         3'b001:  ext = 64'($signed(raw[15:0]));
         3'b010:  ext = 64'($signed(raw[31:0]));
         3'b100:  ext = $signed({56'd0, raw[7:0]});
         3'b101:  ext = $signed({48'd0, raw[15:0]});
         3'b110:  ext = $signed({32'd0, raw[31:0]});
         default: ext = $signed(raw);
      endcase
      return ext;
   endfunction

   always_comb begin
      case (funct3_q[1:0])
         2'd0:    last_k = 3'd0;
         2'd1:    last_k = 3'd1;
         2'd2:    last_k = 3'd3;
         default: last_k = 3'd7;
      endcase
      // the byte returned this cycle lands in assembly lane k
      asm_data = resp_data_q;
      asm_data[{k_q, 3'b000} +: 8] = bus.mem_read_data[7:0];
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt        = state;
      bus.req_ready    = 1'b0;
      bus.resp_valid   = 1'b0;
      bus.mem_write_en = 1'b0;
      bus.mem_funct3   = 3'b111;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               if (reject)          state_nxt = RESP;
`ifdef LSU_MISALIGNED_SPLIT_EN
               else if (misaligned) state_nxt = SPLIT;
`else
               else if (misaligned) state_nxt = RESP;
`endif
               else                 state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            bus.mem_write_en = store_q;
            bus.mem_funct3   = funct3_q;
            state_nxt        = RESP;
         end
`ifdef LSU_MISALIGNED_SPLIT_EN
         SPLIT: begin
            bus.mem_write_en = store_q;
            bus.mem_funct3   = store_q ? 3'b000 : 3'b100;
            if (k_q == last_k) state_nxt = RESP;
         end
`endif
         RESP: begin
            bus.resp_valid = 1'b1;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         store_q     <= 1'b0;
         funct3_q    <= 3'b111;
         resp_data_q <= '0;
         mis_q       <= 1'b0;
         fault_q     <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
         k_q         <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  store_q     <= bus.req_store;
                  funct3_q    <= bus.req_funct3;
                  resp_data_q <= '0;
                  fault_q     <= reject;
                  mis_q       <= 1'b0;
                  if (!reject) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                     mem_addr_q  <= bus.req_addr[AddrWidth-1:0];
                     mem_wdata_q <= bus.req_wdata;
                     k_q         <= '0;
`else
                     // memory port keeps its last values when nothing is issued
                     if (misaligned) begin
                        mis_q <= 1'b1;
                     end else begin
                        mem_addr_q  <= bus.req_addr[AddrWidth-1:0];
                        mem_wdata_q <= bus.req_wdata;
                     end
`endif
                  end
               end
            end
            ACCESS: begin
               if (!store_q) resp_data_q <= bus.mem_read_data;
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            SPLIT: begin
               if (!store_q) resp_data_q <= (k_q == last_k) ? load_ext(asm_data, funct3_q) : asm_data;
               // advance only between bytes so the port holds the last issued byte
               if (k_q != last_k) begin
                  k_q         <= k_q + 3'd1;
                  mem_addr_q  <= mem_addr_q + {{(AddrWidth-1){1'b0}}, 1'b1};
                  mem_wdata_q <= {8'd0, mem_wdata_q[63:8]};
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign bus.resp_data       = resp_data_q;
   assign bus.resp_misaligned = mis_q;
   assign bus.resp_fault      = fault_q;
   assign bus.mem_addr        = mem_addr_q;
   assign bus.mem_write_data  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_rv64.sv
// tb_lsu_rv64
//   Drives directed and random load/store requests into lsu_rv64, models the
//   data memory on the memory port, and checks every cycle of each transaction
//   against a byte-level reference model of the architectural behaviour.
module tb_lsu_rv64;
   localparam int AW    = 14;
   localparam int MEMSZ = 1 << AW;
`ifdef LSU_MISALIGNED_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lsu_rv64_if #(.AddrWidth(AW)) bus ();
   lsu_rv64 #(.AddrWidth(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [7:0] mem     [MEMSZ];
   logic [7:0] ref_mem [MEMSZ];
   logic       mem_init;
   int         vectors = 0;
   int         miscompares = 0;
   longint     cyc = 0;

   // expected transaction, set by the driver, consumed by the compare process
   bit          track = 1'b0;
   longint      c0;
   int          cj;
   int          exp_l;
   logic [63:0] exp_data;
   bit          exp_mis, exp_fault, exp_split, exp_store, exp_mem;
   logic [2:0]  exp_f3;
   logic [63:0] exp_addr, exp_wdata;
   logic [63:0] last_data;
   bit          last_mis, last_fault;
   int          last_lat;

   function automatic logic [63:0] extend(input logic [63:0] v, input int n, input bit sgn);
      logic [63:0] r;
      r = v;
      if (n < 8) begin
         r = v & ((64'd1 << (8 * n)) - 64'd1);
         if (sgn && r[8 * n - 1]) r = r | ~((64'd1 << (8 * n)) - 64'd1);
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // data memory: combinational read with funct3 extension, byte writes on the edge
   always_comb begin : env_rd
      logic [63:0] raw;
      int          n;
      raw = '0;
      n   = 1 << bus.mem_funct3[1:0];
      for (int i = 0; i < 8; i++)
         if (i < n) raw[8 * i +: 8] = mem[(int'(bus.mem_addr) + i) % MEMSZ];
      bus.mem_read_data = extend(raw, n, !bus.mem_funct3[2]);
   end

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < MEMSZ; i++) mem[i] <= 8'(i * 37 + 11);
      end else if (bus.mem_write_en) begin
         for (int i = 0; i < 8; i++)
            if (i < (1 << bus.mem_funct3[1:0]))
               mem[(int'(bus.mem_addr) + i) % MEMSZ] <= bus.mem_write_data[8 * i +: 8];
      end
   end

   // reference: what a request must produce, straight from the architectural rules
   task automatic model(input bit store, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wdata);
      bit          illegal, oor, mis;
      int          n;
      logic [63:0] raw;
      n         = 1 << f3[1:0];
      illegal   = store ? f3[2] : (f3 == 3'b111);
      oor       = ((addr >> AW) != 0) || (addr + 64'(n) - 1 > 64'(MEMSZ - 1));
      mis       = (addr % 64'(n)) != 0;
      exp_store = store;
      exp_f3    = f3;
      exp_addr  = addr;
      exp_wdata = wdata;
      exp_data  = '0;
      exp_mis   = 1'b0;
      exp_fault = 1'b0;
      exp_split = 1'b0;
      exp_mem   = 1'b0;
      if (illegal || oor) begin
         exp_l = 1; exp_fault = 1'b1;
      end else if (mis && !SPLIT_EN) begin
         exp_l = 1; exp_mis = 1'b1;
      end else begin
         exp_mem   = 1'b1;
         exp_split = mis;
         exp_l     = mis ? n + 1 : 2;
         if (store) begin
            for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[8 * i +: 8];
         end else begin
            raw = '0;
            for (int i = 0; i < n; i++) raw[8 * i +: 8] = ref_mem[int'(addr) + i];
            exp_data = extend(raw, n, !f3[2]);
         end
      end
   endtask

   // per-cycle comparison of one transaction; cycle cj=1 is the cycle after acceptance
   always @(negedge clk) begin
      if (track) begin
         cj = int'(cyc - c0) + 1;
         chk("resp_valid", 64'(bus.resp_valid), 64'(cj == exp_l));
         chk("req_ready", 64'(bus.req_ready), 64'(cj > exp_l));
         if (exp_mem && cj < exp_l) begin
            chk("mem_write_en", 64'(bus.mem_write_en), 64'(exp_store));
            chk("mem_funct3", 64'(bus.mem_funct3),
                64'(exp_split ? (exp_store ? 3'b000 : 3'b100) : exp_f3));
            chk("mem_addr", 64'(bus.mem_addr), (exp_addr + 64'(cj - 1)) & 64'(MEMSZ - 1));
            if (exp_store && exp_split)
               chk("mem_wbyte", 64'(bus.mem_write_data[7:0]), (exp_wdata >> (8 * (cj - 1))) & 64'hFF);
            else if (exp_store)
               chk("mem_wdata", bus.mem_write_data, exp_wdata);
         end else if (cj <= exp_l) begin
            chk("mem_idle_we", 64'(bus.mem_write_en), 64'd0);
            chk("mem_idle_f3", 64'(bus.mem_funct3), 64'h7);
         end
         if (cj == exp_l) begin
            chk("resp_data", bus.resp_data, exp_data);
            chk("resp_misaligned", 64'(bus.resp_misaligned), 64'(exp_mis));
            chk("resp_fault", 64'(bus.resp_fault), 64'(exp_fault));
            last_data  = bus.resp_data;
            last_mis   = bus.resp_misaligned;
            last_fault = bus.resp_fault;
            last_lat   = cj;
         end
         if (cj > exp_l) track = 1'b0;
      end
   end

   task automatic issue(input bit store, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wdata);
      last_lat = 0;
      model(store, f3, addr, wdata);
      bus.req_valid  = 1'b1;
      bus.req_store  = store;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      c0    = cyc;
      track = 1'b1;
      for (int t = 0; t < 30 && track; t++) @(posedge clk);
      #1;
      if (track) begin
         miscompares++;
         $display("FAIL timeout: transaction at %h never completed", addr);
         track = 1'b0;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          bad;
      bit          st;
      logic [2:0]  f3;
      logic [63:0] a;
      int          r;

      rst = 1'b1;
      mem_init = 1'b1;
      bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'b000;
      bus.req_addr = '0; bus.req_wdata = '0;
      for (int i = 0; i < MEMSZ; i++) ref_mem[i] = 8'(i * 37 + 11);
      repeat (2) @(posedge clk);
      #1;
      // a request held during reset must be ignored
      bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b011;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_resp_data", bus.resp_data, 64'd0);
      chk("rst_resp_mis", 64'(bus.resp_misaligned), 64'd0);
      chk("rst_resp_fault", 64'(bus.resp_fault), 64'd0);
      chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      chk("rst_mem_wdata", bus.mem_write_data, 64'd0);
      chk("rst_mem_we", 64'(bus.mem_write_en), 64'd0);
      chk("rst_mem_f3", 64'(bus.mem_funct3), 64'h7);
      mem_init = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // directed cases with hand-computed results
      issue(1'b1, 3'b011, 64'h10, 64'h8877665544332211);
      issue(1'b0, 3'b011, 64'h10, 64'h0);
      chk("ld_data", last_data, 64'h8877665544332211);
      chk("ld_latency", 64'(last_lat), 64'd2);
      chk("ld_flags", {62'd0, last_mis, last_fault}, 64'd0);
      issue(1'b1, 3'b000, 64'h20, 64'h80);
      issue(1'b0, 3'b000, 64'h20, 64'h0);
      chk("lb_data", last_data, 64'hFFFFFFFFFFFFFF80);
      issue(1'b0, 3'b100, 64'h20, 64'h0);
      chk("lbu_data", last_data, 64'h0000000000000080);
      issue(1'b0, 3'b010, 64'h3FFE, 64'h0);
      chk("lw_top_fault", 64'(last_fault), 64'd1);
      chk("lw_top_data", last_data, 64'd0);
      chk("lw_top_latency", 64'(last_lat), 64'd1);
      issue(1'b1, 3'b011, 64'h4000, 64'h1234);
      chk("sd_oor_fault", 64'(last_fault), 64'd1);
      issue(1'b1, 3'b010, 64'h21, 64'hDEADBEEF);
      issue(1'b0, 3'b010, 64'h21, 64'h0);
      if (SPLIT_EN) begin
         chk("lw_split_data", last_data, 64'hFFFFFFFFDEADBEEF);
         chk("lw_split_latency", 64'(last_lat), 64'd5);
      end else begin
         chk("lw_mis_flag", 64'(last_mis), 64'd1);
         chk("lw_mis_data", last_data, 64'd0);
      end
      issue(1'b1, 3'b100, 64'h40, 64'h55);
      chk("st_f3_fault", 64'(last_fault), 64'd1);
      issue(1'b0, 3'b111, 64'h40, 64'h0);
      chk("ld_f3_fault", 64'(last_fault), 64'd1);

      // reset in the memory cycle of an aligned store
      bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b011;
      bus.req_addr = 64'h30; bus.req_wdata = 64'hCAFEF00DCAFEF00D;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("abort_we_before", 64'(bus.mem_write_en), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort_we_now", 64'(bus.mem_write_en), 64'd0);
      chk("abort_resp_valid", 64'(bus.resp_valid), 64'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_resp_after", 64'(bus.resp_valid), 64'd0);
      chk("abort_ready", 64'(bus.req_ready), 64'd1);

      // randomized traffic, biased toward a small window so loads see prior stores
      for (int i = 0; i < 400; i++) begin
         st = 1'($urandom % 2);
         f3 = 3'($urandom % 8);
         r  = int'($urandom % 10);
         if (r == 0)      a = {$urandom, $urandom};
         else if (r == 1) a = 64'(MEMSZ - 8 + int'($urandom % 8));
         else if (r == 2) a = 64'($urandom % MEMSZ);
         else             a = 64'($urandom_range(256, 320));
         issue(st, f3, a, {$urandom, $urandom});
      end

      bad = 0;
      for (int i = 0; i < MEMSZ; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk("mem_image", 64'(bad), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/lsu_rv64.md
# lsu_rv64

Load/store unit for the RV64 datapath, sitting directly upstream of the byte-addressed data memory. It accepts one load or store request per handshake from the execute stage, registers it, and checks range and encoding. It drives the memory's addr/write_data/write_en/funct3 port for exactly the cycles needed and returns a single-cycle response carrying the extended load data or a fault. Misaligned accesses are either split into byte accesses or rejected, depending on configuration.

## Interface
- AddrWidth, 14, memory address width; must match the data memory it drives.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_addr  in  64  byte address (already base+offset).
- req_wdata  in  64  store data, LSB-aligned.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV64 funct3 (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD).
- resp_valid  out  1  one-cycle response pulse; no backpressure.
- resp_data  out  64  extended load data; 0 for stores and faults.
- resp_misaligned  out  1  misaligned-address exception.
- resp_fault  out  1  access fault (out of range or illegal funct3).
- mem_addr  out  AddrWidth  to data memory addr.
- mem_write_data  out  64  to data memory write_data.
- mem_write_en  out  1  to data memory write_en.
- mem_funct3  out  3  to data memory funct3.
- mem_read_data  in  64  from data memory (combinational read).

## Operation
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE: req_ready=1. req_valid&&req_ready latches addr, wdata, store, funct3; computes size N (1/2/4/8 from funct3[1:0]).
- Checks at accept, priority order: illegal funct3 (load 3'b111, store funct3[2]=1) -> fault; req_addr[63:AddrWidth]!=0 or addr+N-1 > 2^AddrWidth-1 -> fault; addr mod N != 0 -> misaligned. Any flagged request goes straight to RESP, with no memory cycle and mem_write_en never asserted.
- Aligned, legal: IDLE -> ACCESS -> RESP -> IDLE.
- ACCESS: mem_addr=addr[AddrWidth-1:0], mem_funct3=req funct3, mem_write_data=wdata, mem_write_en=store. For a load, mem_read_data is captured into resp_data.
- RESP: resp_valid=1 with registered data/flags for exactly one cycle, then IDLE.
- Idle values of memory port (IDLE/RESP): mem_write_en=0, mem_funct3=3'b111, mem_addr and mem_write_data hold their last values.
- Load extension in the split path: LB/LH/LW sign-extend from bit 8N-1; LBU/LHU/LWU zero-extend; LD has no extension.

## Timing
- Request accepted in cycle 0. Aligned access: memory cycle 1, resp_valid cycle 2, req_ready high again cycle 3. Throughput is 1 request per 3 cycles.
- Fault or misaligned (no split): resp_valid in cycle 1, req_ready high in cycle 2.
- Split access: byte k is issued in cycle 1+k (k=0..N-1), resp_valid in cycle N+1, req_ready in cycle N+2.
- mem_write_en is high only in ACCESS/SPLIT cycles of a store; it is never high two cycles for the same byte.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_misaligned=0, resp_fault=0, mem_addr=0, mem_write_data=0, mem_write_en=0, mem_funct3=3'b111.
- rst is asynchronous mid-operation: the unit returns to IDLE immediately, mem_write_en drops in the same cycle, and the pending response is discarded. Bytes already written by a split store stay written.
- Requests with req_valid high while rst is high are ignored.

## Configuration
- LSU_MISALIGNED_SPLIT_EN defined: a legal, in-range misaligned request enters SPLIT instead of faulting. In SPLIT a 3-bit byte counter k issues mem_addr=addr+k.
  - Stores: mem_funct3=SB and mem_write_data[7:0]=wdata byte k.
  - Loads: mem_funct3=LBU, and mem_read_data[7:0] is placed into assembly byte k.
  - After k=N-1 the unit extends the assembled data and goes to RESP with resp_misaligned=0.
- Undefined: the SPLIT state and counter are not compiled. A misaligned request responds with resp_misaligned=1, resp_data=0 and no memory activity.

## Test plan
- SD addr 0x10 data 0x8877665544332211, then LD 0x10 -> resp_valid in cycle 2, resp_data=0x8877665544332211, no flags.
- SB 0x20 data 0x80, then LB 0x20 -> resp_data=0xFFFFFFFFFFFFFF80; LBU 0x20 -> 0x0000000000000080.
- LW at 0x3FFE with AddrWidth=14 -> resp_fault=1, resp_data=0, resp_valid in cycle 1; store at 0x4000 -> fault with mem_write_en never high.
- SW 0x21 data 0xDEADBEEF. With macro: bytes written at 0x21..0x24 over cycles 1-4, and LW 0x21 returns 0xFFFFFFFFDEADBEEF in cycle 5. Without macro: resp_misaligned=1 and no write.
- Store funct3=3'b100 -> resp_fault=1; load funct3=3'b111 -> resp_fault=1.
- Assert rst during cycle 1 of an aligned SD -> mem_write_en=0 immediately, no resp_valid, req_ready=1 after reset release.
